instr_fetch_mem: RTL and testbench
==================================

INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 Parameter IW, default 16, instruction/data width in bits (multiple of 8).
REQ-002 Parameter AW, default 16, byte-address width.
REQ-003 Parameter DEPTH, default 128, number of IW-bit words stored.
REQ-004 Parameter LAT, default 1, read latency in cycles, legal range 1..3.
REQ-005 Parameter FILL, default 16'hEFFF (halt), word written into every location during init.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 fetch_req  input  1  fetch request, qualified by fetch_ready.
REQ-009 fetch_addr  input  AW  byte address of requested instruction.
REQ-010 fetch_ready  output  1  request accepted this cycle when high together with fetch_req.
REQ-011 stall  input  1  freeze pipeline and outputs.
REQ-012 flush  input  1  discard all in-flight fetches.
REQ-013 inst_valid  output  1  inst/inst_addr/fetch_err valid this cycle.
REQ-014 inst  output  IW  fetched instruction.
REQ-015 inst_addr  output  AW  byte address belonging to inst.
REQ-016 fetch_err  output  1  fetch was misaligned or out of range.
REQ-017 prog_we  input  1  program-load write strobe.
REQ-018 prog_addr  input  AW  byte address for program-load write.
REQ-019 prog_data  input  IW  program-load write data.
REQ-020 init_done  output  1  high once memory clear has completed.

Function
REQ-021 Word index SHALL be addr >> log2(IW/8); address SHALL be misaligned when its low log2(IW/8) bits are nonzero (bit 0 for IW=16).
REQ-022 Address SHALL be out of range when word index >= DEPTH.
REQ-023 FSM states: INIT, RUN; reset enters INIT with clear counter 0.
REQ-024 INIT: one word per cycle written with FILL at counter index, counter increments; after index DEPTH-1 is written, next cycle is RUN and init_done rises; INIT lasts exactly DEPTH cycles.
REQ-025 During INIT fetch_ready SHALL be 0 and prog_we SHALL be ignored.
REQ-026 fetch_ready SHALL equal (state==RUN) && !stall.
REQ-027 Accepted fetch SHALL produce inst_valid exactly LAT cycles later (counting non-stalled cycles only), carrying mem[index], fetch_addr, fetch_err=0.
REQ-028 Misaligned or out-of-range accepted fetch SHALL return inst=FILL, fetch_err=1, inst_valid=1 after LAT cycles; memory untouched.
REQ-029 Back-to-back accepted fetches SHALL sustain one result per cycle, in request order.
REQ-030 stall=1: all pipeline stages and inst/inst_addr/inst_valid/fetch_err SHALL hold; no new request accepted.
REQ-031 flush=1: all in-flight valid bits cleared next cycle; inst_valid 0 next cycle; flush SHALL take priority over stall; a request accepted in the flush cycle SHALL be kept (redirect).
REQ-032 prog_we in RUN SHALL write prog_data to the word if aligned and in range, else ignore; writes SHALL proceed regardless of stall.
REQ-033 Same-cycle prog write and fetch accept of same word: fetch SHALL return the old data (read-before-write).

Reset
REQ-034 On rst low: state INIT, counter 0, init_done 0, fetch_ready 0, inst_valid 0, inst 0, inst_addr 0, fetch_err 0, all pipeline valid bits 0.
REQ-035 Reset mid-INIT or mid-RUN SHALL abort all in-flight fetches and restart the full INIT sequence; memory contents are not reset directly but overwritten by INIT.

Structure
REQ-036 Package imem_pkg SHALL hold FILL default (16'hEFFF), state enum {INIT, RUN}, and the word-index/alignment helper function.
REQ-037 One sub-module im_rdpipe SHALL implement the LAT-stage valid/data/addr/err delay line with stall and flush.

Verification
REQ-038 Reset, then DEPTH=128 -> fetch_ready 0 for 128 cycles, init_done rises cycle 128; fetch 0x0000 returns 16'hEFFF.
REQ-039 prog writes F120@0x00, F121@0x02, 93FF@0x04; fetch 0,2,4 back-to-back, LAT=2 -> inst_valid cycles t+2..t+4 with F120, F121, 93FF, inst_addr 0,2,4.
REQ-040 Fetch 0x0003 -> fetch_err 1, inst EFFF; fetch 0x0100 (index 128) -> fetch_err 1; prog_we to 0x0100 leaves memory unchanged.
REQ-041 Stall 3 cycles with two fetches in flight -> outputs frozen, results appear after stall drops, order preserved; flush with stall -> no stale inst_valid.
REQ-042 Fetch 0x0A with same-cycle prog write F564@0x0A over 134C -> returns 134C, next fetch returns F564.
REQ-043 rst low mid-fetch stream in RUN -> inst_valid 0 immediately, INIT repeats full 128 cycles, previously programmed words read EFFF.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction fetch memory.
package imem_pkg;

  // Halt instruction used to clear memory and to answer bad fetches.
  localparam logic [15:0] FILL_DEFAULT = 16'hEFFF;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  // Result of splitting a byte address into a word index and an alignment flag.
  typedef struct packed {
    logic [31:0] idx;
    logic        misaligned;
  } addr_dec_t;

  // Word index is the byte address shifted by log2(bytes per word); any set
  // bit below that shift means the address does not start a word.
  function automatic addr_dec_t decodeAddr(input logic [31:0] addr, input int unsigned shift);
    addr_dec_t dec;
    dec.idx        = addr >> shift;
    dec.misaligned = (addr & ((32'd1 << shift) - 32'd1)) != 32'd0;
    return dec;
  endfunction

endpackage

// File: rtl/instr_fetch_mem_if.sv
// Fetch, result and program-load signals between a core and the fetch memory.
interface instr_fetch_mem_if #(
  parameter int IW = 16,
  parameter int AW = 16
);
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ready;
  logic          stall;
  logic          flush;
  logic          inst_valid;
  logic [IW-1:0] inst;
  logic [AW-1:0] inst_addr;
  logic          fetch_err;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic          init_done;

  modport master (
    output fetch_req, fetch_addr, stall, flush, prog_we, prog_addr, prog_data,
    input  fetch_ready, inst_valid, inst, inst_addr, fetch_err, init_done
  );

  modport slave (
    input  fetch_req, fetch_addr, stall, flush, prog_we, prog_addr, prog_data,
    output fetch_ready, inst_valid, inst, inst_addr, fetch_err, init_done
  );
endinterface

// File: rtl/im_rdpipe.sv
// LAT-stage delay line carrying fetch results, frozen by stall and emptied by flush.
module im_rdpipe #(
  parameter int IW  = 16,
  parameter int AW  = 16,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          valid_i,
  input  logic [IW-1:0] data_i,
  input  logic [AW-1:0] addr_i,
  input  logic          err_i,
  output logic          valid_o,
  output logic [IW-1:0] data_o,
  output logic [AW-1:0] addr_o,
  output logic          err_o
);

  logic          valid_q [LAT];
  logic [IW-1:0] data_q  [LAT];
  logic [AW-1:0] addr_q  [LAT];
  logic          err_q   [LAT];

  // Shift one stage per unstalled cycle; flush drops every in-flight valid
  // but still takes the request accepted alongside it (a redirect target).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < LAT; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        addr_q[k]  <= '0;
        err_q[k]   <= 1'b0;
      end
    end else begin
      if (flush_i) begin
        for (int k = 0; k < LAT; k++) begin
          valid_q[k] <= 1'b0;
        end
        valid_q[0] <= valid_i;
      end else if (!stall_i) begin
        valid_q[0] <= valid_i;
        for (int k = 1; k < LAT; k++) begin
          valid_q[k] <= valid_q[k-1];
        end
      end
      if (!stall_i) begin
        data_q[0] <= data_i;
        addr_q[0] <= addr_i;
        err_q[0]  <= err_i;
        for (int k = 1; k < LAT; k++) begin
          data_q[k] <= data_q[k-1];
          addr_q[k] <= addr_q[k-1];
          err_q[k]  <= err_q[k-1];
        end
      end
    end
  end

  assign valid_o = valid_q[LAT-1];
  assign data_o  = data_q[LAT-1];
  assign addr_o  = addr_q[LAT-1];
  assign err_o   = err_q[LAT-1];

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction memory with self-clearing init, program-load port and pipelined fetch.
module instr_fetch_mem
  import imem_pkg::*;
#(
  parameter int            IW    = 16,
  parameter int            AW    = 16,
  parameter int            DEPTH = 128,
  parameter int            LAT   = 1,
  parameter logic [IW-1:0] FILL  = IW'(FILL_DEFAULT)
) (
  input logic              clk,
  input logic              rst,
  instr_fetch_mem_if.slave bus
);

  localparam int unsigned SH = $clog2(IW / 8);
  localparam int          CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          initDone_q;

  logic [IW-1:0] mem [DEPTH];

  addr_dec_t     fDec;
  addr_dec_t     pDec;
  logic          fErr;
  logic          pOk;
  logic [CW-1:0] fIdx;
  logic [CW-1:0] pIdx;
  logic [IW-1:0] rdData;
  logic          accept;

  assign fDec = decodeAddr(32'(bus.fetch_addr), SH);
  assign pDec = decodeAddr(32'(bus.prog_addr), SH);
  assign fErr = fDec.misaligned || (fDec.idx >= 32'(DEPTH));
  assign pOk  = !pDec.misaligned && (pDec.idx < 32'(DEPTH));
  assign fIdx = fDec.idx[CW-1:0];
  assign pIdx = pDec.idx[CW-1:0];

  // Memory is read combinationally in the accept cycle, so a same-cycle
  // program write to the same word only lands after this read.
  assign rdData = fErr ? FILL : mem[fIdx];

  assign bus.fetch_ready = (state_q == RUN) && !bus.stall;
  assign bus.init_done   = initDone_q;
  assign accept          = bus.fetch_req && bus.fetch_ready;

  // Init sequencer: walk every word once after reset, then run forever.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      initDone_q <= 1'b0;
    end else if (state_q == INIT) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CW'(DEPTH - 1)) begin
        state_q    <= RUN;
        initDone_q <= 1'b1;
      end
    end
  end

  // Storage writes: the clear pattern during init, program loads afterwards
  // (independent of stall); bad program addresses are dropped.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[cnt_q] <= FILL;
    end else if (bus.prog_we && pOk) begin
      mem[pIdx] <= bus.prog_data;
    end
  end

  im_rdpipe #(
    .IW  (IW),
    .AW  (AW),
    .LAT (LAT)
  ) u_rdpipe (
    .clk     (clk),
    .rst     (rst),
    .stall_i (bus.stall),
    .flush_i (bus.flush),
    .valid_i (accept),
    .data_i  (rdData),
    .addr_i  (bus.fetch_addr),
    .err_i   (fErr),
    .valid_o (bus.inst_valid),
    .data_o  (bus.inst),
    .addr_o  (bus.inst_addr),
    .err_o   (bus.fetch_err)
  );

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Self-checking bench: vector table plus corner sequences, results via scoreboard.
module tb_instr_fetch_mem;
  import imem_pkg::*;

  localparam int IW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 128;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  instr_fetch_mem_if #(.IW(IW), .AW(AW)) bus ();

  instr_fetch_mem #(
    .IW    (IW),
    .AW    (AW),
    .DEPTH (DEPTH),
    .LAT   (LAT),
    .FILL  (16'hEFFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [IW-1:0] data;
    logic [AW-1:0] addr;
    logic          err;
    int            tick;
  } exp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] pa;
    logic [IW-1:0] pd;
    logic          req;
    logic [AW-1:0] fa;
    logic          st;
    logic          fl;
    logic [IW-1:0] ed;
    logic          ee;
  } vec_t;

  exp_t sbQ[$];
  vec_t vecs[$];

  int checks = 0;
  int errors = 0;

  logic [IW-1:0] curExpData = '0;
  logic          curExpErr  = 1'b0;

  int            edges = 0;
  int            tick  = 0;
  bit            stallPrev = 1'b0;
  bit            flushPrev = 1'b0;
  logic          prevValid;
  logic [IW-1:0] prevInst;
  logic [AW-1:0] prevAddr;
  logic          prevErr;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, plus the result
  // expected for a fetch accepted in this cycle.
  task automatic applyStimulus(input logic we, input logic [AW-1:0] pa, input logic [IW-1:0] pd,
                               input logic req, input logic [AW-1:0] fa, input logic st,
                               input logic fl, input logic [IW-1:0] ed, input logic ee);
    @(posedge clk);
    #1;
    bus.prog_we    = we;
    bus.prog_addr  = pa;
    bus.prog_data  = pd;
    bus.fetch_req  = req;
    bus.fetch_addr = fa;
    bus.stall      = st;
    bus.flush      = fl;
    curExpData     = ed;
    curExpErr      = ee;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    end
  endtask

  task automatic fetch(input logic [AW-1:0] fa, input logic [IW-1:0] ed, input logic ee);
    applyStimulus(1'b0, '0, '0, 1'b1, fa, 1'b0, 1'b0, ed, ee);
  endtask

  // Monitor: checks handshake and init timing each cycle, scores results,
  // and queues the expectation of every accepted fetch.
  always @(negedge clk) begin
    bit   expReady;
    bit   newOut;
    bit   due;
    exp_t e;
    if (!rst) begin
      checkOutput("reset inst_valid", 32'(bus.inst_valid), 32'd0);
      checkOutput("reset inst", 32'(bus.inst), 32'd0);
      checkOutput("reset inst_addr", 32'(bus.inst_addr), 32'd0);
      checkOutput("reset fetch_err", 32'(bus.fetch_err), 32'd0);
      checkOutput("reset fetch_ready", 32'(bus.fetch_ready), 32'd0);
      checkOutput("reset init_done", 32'(bus.init_done), 32'd0);
      sbQ.delete();
      edges     = 0;
      tick      = 0;
      stallPrev = 1'b0;
      flushPrev = 1'b0;
    end else begin
      expReady = (edges >= DEPTH) && !bus.stall;
      checkOutput("fetch_ready", 32'(bus.fetch_ready), 32'(expReady));
      checkOutput("init_done", 32'(bus.init_done), 32'(edges >= DEPTH));
      if (stallPrev && !flushPrev) begin
        checkOutput("stall hold inst_valid", 32'(bus.inst_valid), 32'(prevValid));
        checkOutput("stall hold inst", 32'(bus.inst), 32'(prevInst));
        checkOutput("stall hold inst_addr", 32'(bus.inst_addr), 32'(prevAddr));
        checkOutput("stall hold fetch_err", 32'(bus.fetch_err), 32'(prevErr));
      end
      if (flushPrev) begin
        checkOutput("post-flush inst_valid", 32'(bus.inst_valid), 32'd0);
      end
      newOut = bus.inst_valid && (!stallPrev || flushPrev);
      due    = (sbQ.size() > 0) && ((tick - sbQ[0].tick) >= LAT);
      if (due) begin
        e = sbQ.pop_front();
        checkOutput("result present", 32'(newOut), 32'd1);
        if (newOut) begin
          checkOutput("result inst", 32'(bus.inst), 32'(e.data));
          checkOutput("result inst_addr", 32'(bus.inst_addr), 32'(e.addr));
          checkOutput("result fetch_err", 32'(bus.fetch_err), 32'(e.err));
        end
      end else begin
        checkOutput("spurious result", 32'(newOut), 32'd0);
      end
      if (bus.flush) sbQ.delete();
      if (expReady && bus.fetch_req) begin
        sbQ.push_back('{curExpData, bus.fetch_addr, curExpErr, tick});
      end
      if (!bus.stall) tick++;
      stallPrev = bus.stall;
      flushPrev = bus.flush;
      edges++;
    end
    prevValid = bus.inst_valid;
    prevInst  = bus.inst;
    prevAddr  = bus.inst_addr;
    prevErr   = bus.fetch_err;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.prog_we    = 1'b0;
    bus.prog_addr  = '0;
    bus.prog_data  = '0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;

    // Vector table: {we, pa, pd, req, fa, stall, flush, expected inst, expected err}
    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 16'hEFFF, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h00FE, 1'b0, 1'b0, 16'hEFFF, 1'b0});
    vecs.push_back('{1'b1, 16'h0000, 16'hF120, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{1'b1, 16'h0002, 16'hF121, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{1'b1, 16'h0004, 16'h93FF, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{1'b1, 16'h000A, 16'h134C, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{1'b1, 16'h0100, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{1'b1, 16'h0003, 16'hAAAA, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{1'b1, 16'h000C, 16'h5A5A, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 16'hF120, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0002, 1'b0, 1'b0, 16'hF121, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0004, 1'b0, 1'b0, 16'h93FF, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0003, 1'b0, 1'b0, 16'hEFFF, 1'b1});
    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0, 16'hEFFF, 1'b1});
    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0, 16'hEFFF, 1'b1});
    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 16'hF120, 1'b0});
    vecs.push_back('{1'b1, 16'h000A, 16'hF564, 1'b1, 16'h000A, 1'b0, 1'b0, 16'h134C, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h000A, 1'b0, 1'b0, 16'hF564, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0002, 1'b0, 1'b0, 16'hF121, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h000C, 1'b0, 1'b0, 16'h5A5A, 1'b0});

    // Reset, then hold fetch requests and a stray program write during init.
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 120; i++) begin
      applyStimulus((i == 100), 16'h0000, 16'h1111, 1'b1, 16'h0000, 1'b0, 1'b0, 16'hEFFF, 1'b0);
    end
    idle(12);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].we, vecs[i].pa, vecs[i].pd, vecs[i].req, vecs[i].fa,
                    vecs[i].st, vecs[i].fl, vecs[i].ed, vecs[i].ee);
    end
    idle(4);

    // Stall three cycles with two fetches in flight.
    fetch(16'h0000, 16'hF120, 1'b0);
    fetch(16'h0002, 16'hF121, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b1, 16'h0004, 1'b1, 1'b0, 16'h93FF, 1'b0);
    end
    idle(4);

    // Flush together with stall drops the fetch still in flight.
    fetch(16'h0004, 16'h93FF, 1'b0);
    fetch(16'h0000, 16'hF120, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1, '0, 1'b0);
    idle(4);

    // Flush with a redirect fetch accepted in the same cycle.
    fetch(16'h0000, 16'hF120, 1'b0);
    fetch(16'h0002, 16'hF121, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1, 16'h0004, 1'b0, 1'b1, 16'h93FF, 1'b0);
    idle(4);

    // Asynchronous reset in the middle of a fetch stream.
    fetch(16'h0000, 16'hF120, 1'b0);
    fetch(16'h0002, 16'hF121, 1'b0);
    fetch(16'h0004, 16'h93FF, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 checkOutput("async reset inst_valid", 32'(bus.inst_valid), 32'd0);
    bus.fetch_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle(130);
    fetch(16'h0000, 16'hEFFF, 1'b0);
    fetch(16'h000A, 16'hEFFF, 1'b0);
    fetch(16'h000C, 16'hEFFF, 1'b0);
    idle(4);

    checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
